multiport_prf: RTL

MULTIPORT_PRF -- requirements
Module: multiport_prf

---
 rtl/multiport_prf_pkg.sv | 14 +
 rtl/multiport_prf_if.sv | 32 +++
 rtl/multiport_prf_ready_table.sv | 39 +++
 rtl/multiport_prf.sv | 74 +++++++
 4 files changed

// File: rtl/multiport_prf_pkg.sv
// Shared sizing defaults for the physical register file and its ready-bit table.
package prf_pkg;
    localparam int DEF_DEPTH  = 64;
    localparam int DEF_WIDTH  = 32;
    localparam int DEF_NUM_RD = 4;
    localparam int DEF_NUM_WR = 2;
    localparam int DEF_NUM_AL = 2;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    localparam int DEF_AW = $clog2(DEF_DEPTH);
endpackage

// File: rtl/multiport_prf_if.sv
// Read, write, allocate and flush bundle of the multiport register file.
interface multiport_prf_if
    import prf_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int NUM_WR = DEF_NUM_WR,
    parameter int NUM_AL = DEF_NUM_AL
) ();
    localparam int AW = $clog2(DEPTH);

    logic [NUM_RD*AW-1:0]    raddr;
    logic [NUM_RD*WIDTH-1:0] rdata;
    logic [NUM_RD-1:0]       rready;
    logic [NUM_WR-1:0]       we;
    logic [NUM_WR*AW-1:0]    waddr;
    logic [NUM_WR*WIDTH-1:0] wdata;
    logic [NUM_AL-1:0]       al_valid;
    logic [NUM_AL*AW-1:0]    al_addr;
    logic                    flush;

    modport master (
        output raddr, we, waddr, wdata, al_valid, al_addr, flush,
        input  rdata, rready
    );

    modport slave (
        input  raddr, we, waddr, wdata, al_valid, al_addr, flush,
        output rdata, rready
    );
endinterface

// File: rtl/multiport_prf_ready_table.sv
// One ready bit per physical register: set by writes, cleared by allocation,
// forced to 1 by flush and reset. Register 0 is permanently ready.
module prf_ready_table
    import prf_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_WR = DEF_NUM_WR,
    parameter int NUM_AL = DEF_NUM_AL,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_WR-1:0]    we,
    input  logic [NUM_WR*AW-1:0] waddr,
    input  logic [NUM_AL-1:0]    al_valid,
    input  logic [NUM_AL*AW-1:0] al_addr,
    input  logic                 flush,
    output logic [DEPTH-1:0]     ready
);
    logic [DEPTH-1:0] ready_nxt;

    // Clears are applied after sets so an allocation wins over a same-cycle write.
    always_comb begin
        ready_nxt = ready;
        for (int j = 0; j < NUM_WR; j++) begin
            if (we[j]) ready_nxt[waddr[j*AW +: AW]] = 1'b1;
        end
        for (int k = 0; k < NUM_AL; k++) begin
            if (al_valid[k]) ready_nxt[al_addr[k*AW +: AW]] = 1'b0;
        end
        if (flush) ready_nxt = '1;
        ready_nxt[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) ready <= '1;
        else     ready <= ready_nxt;
    end
endmodule

// File: rtl/multiport_prf.sv
// Multiport physical register file: combinational reads with same-cycle write
// bypass, prioritised writes, and a ready bit per register for operand tracking.
module multiport_prf
    import prf_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_RD = DEF_NUM_RD,
    parameter int NUM_WR = DEF_NUM_WR,
    parameter int NUM_AL = DEF_NUM_AL
) (
    input logic           clk,
    input logic           rst,
    multiport_prf_if.slave bus
);
    localparam int AW = addr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] ready;

    prf_ready_table #(
        .DEPTH  (DEPTH),
        .NUM_WR (NUM_WR),
        .NUM_AL (NUM_AL),
        .AW     (AW)
    ) u_ready (
        .clk      (clk),
        .rst      (rst),
        .we       (bus.we),
        .waddr    (bus.waddr),
        .al_valid (bus.al_valid),
        .al_addr  (bus.al_addr),
        .flush    (bus.flush),
        .ready    (ready)
    );

    // Later ports are visited last, so the highest-index writer wins a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < DEPTH; n++) mem[n] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.we[j] && bus.waddr[j*AW +: AW] != '0)
                    mem[bus.waddr[j*AW +: AW]] <= bus.wdata[j*WIDTH +: WIDTH];
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        logic             rdy;

        assign addr = bus.raddr[i*AW +: AW];

        always_comb begin
            data = mem[addr];
            rdy  = ready[addr];
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.we[j] && bus.waddr[j*AW +: AW] == addr) begin
                    data = bus.wdata[j*WIDTH +: WIDTH];
                    rdy  = 1'b1;
                end
            end
            if (addr == '0) begin
                data = '0;
                rdy  = 1'b1;
            end
        end

        assign bus.rdata[i*WIDTH +: WIDTH] = data;
        assign bus.rready[i]               = rdy;
    end
endmodule
